// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready input handshake.
// Words stream out one bit per cycle; a new word can be taken on the last bit for gapless output.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign accept = data_valid & data_ready;

    // The transmitted bit always sits at OUT_IDX, so each cycle the register moves one step toward it.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = data_in;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    if (accept) begin
                        shift_d = data_in;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        shift_d = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, so no input reaches x, x_valid or last_bit.
    always_comb begin
        x_valid    = (state_q == SHIFT);
        last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        x          = (state_q == SHIFT) ? shift_q[OUT_IDX] : IDLE_BIT;
        data_ready = (state_q == IDLE) || last_bit;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomised and directed checks of bit_serializer against a queue-based bit-stream model.
// Two instances (MSB-first and LSB-first) share the same stimulus.
module tb_bit_serializer;

    logic       clk;
    logic       resetN;
    logic [7:0] dataIn;
    logic       dataValid;
    logic       dataReady, x, xValid, lastBit;
    logic       dataReadyL, xL, xValidL, lastBitL;

    int checks = 0;
    int errors = 0;

    // Expected bits still to appear on x, head = bit currently shown.
    logic qM[$];
    logic qL[$];

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .reset_n(resetN), .data_in(dataIn), .data_valid(dataValid),
        .data_ready(dataReady), .x(x), .x_valid(xValid), .last_bit(lastBit)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dutLsb (
        .clk(clk), .reset_n(resetN), .data_in(dataIn), .data_valid(dataValid),
        .data_ready(dataReadyL), .x(xL), .x_valid(xValidL), .last_bit(lastBitL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareModel();
        logic expX, expXL, expValid, expLast, expReady;
        expX     = (qM.size() > 0) ? qM[0] : 1'b1;
        expXL    = (qL.size() > 0) ? qL[0] : 1'b1;
        expValid = (qM.size() > 0);
        expLast  = (qM.size() == 1);
        expReady = (qM.size() <= 1);
        checkOutput("x", {31'd0, x}, {31'd0, expX});
        checkOutput("x_valid", {31'd0, xValid}, {31'd0, expValid});
        checkOutput("last_bit", {31'd0, lastBit}, {31'd0, expLast});
        checkOutput("data_ready", {31'd0, dataReady}, {31'd0, expReady});
        checkOutput("lsb_x", {31'd0, xL}, {31'd0, expXL});
        checkOutput("lsb_x_valid", {31'd0, xValidL}, {31'd0, expValid});
        checkOutput("lsb_last_bit", {31'd0, lastBitL}, {31'd0, expLast});
        checkOutput("lsb_data_ready", {31'd0, dataReadyL}, {31'd0, expReady});
    endtask

    // Drive one cycle's inputs at the falling edge, advance the model at the rising edge, check at the next fall.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        logic rdy;
        rdy       = (qM.size() <= 1);
        dataValid = v;
        dataIn    = d;
        @(posedge clk);
        if (qM.size() > 0) begin
            void'(qM.pop_front());
            void'(qL.pop_front());
        end
        if (v && rdy) begin
            for (int i = 0; i < 8; i++) begin
                qM.push_back(d[7-i]);
                qL.push_back(d[i]);
            end
        end
        @(negedge clk);
        compareModel();
    endtask

    // Asynchronous reset between edges, with a handshake offered while it is held.
    task automatic resetMidWord();
        #2;
        resetN    = 1'b0;
        dataValid = 1'b1;
        dataIn    = 8'($urandom);
        qM.delete();
        qL.delete();
        #1;
        compareModel();
        @(posedge clk);
        @(negedge clk);
        compareModel();
        resetN = 1'b1;
    endtask

    initial begin
        logic [7:0]  streamM, streamL;
        logic [15:0] stream16;
        logic [2:0]  win;
        int          lastCnt, readyCnt;

        resetN    = 1'b0;
        dataValid = 1'b1;
        dataIn    = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compareModel();
        resetN = 1'b1;

        // Single word, MSB first; same word on the LSB-first instance.
        streamM = '0; streamL = '0; lastCnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i == 0, 8'h66);
            streamM    = {streamM[6:0], x};
            streamL[i] = xL;
            lastCnt   += int'(lastBit);
        end
        checkOutput("word66_msb", {24'd0, streamM}, 32'h66);
        checkOutput("word66_lsb", {24'd0, streamL}, 32'h66);
        checkOutput("word66_lastcnt", lastCnt, 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("idle_after66", {30'd0, x, xValid}, 32'b10);

        // LSB first with an asymmetric word.
        streamL = '0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i == 0, 8'h06);
            streamL[i] = xL;
        end
        checkOutput("word06_lsb", {24'd0, streamL}, 32'h06);
        applyStimulus(1'b0, 8'h00);

        // Back-to-back words with data_valid held high.
        stream16 = '0; readyCnt = 0;
        for (int i = 0; i < 17; i++) begin
            if (i >= 1 && i <= 15) readyCnt += int'(dataReady);
            applyStimulus(i <= 8, (i == 0) ? 8'hA5 : 8'h3C);
            if (i < 16) stream16 = {stream16[14:0], x & xValid};
        end
        checkOutput("b2b_stream", {16'd0, stream16}, 32'hA53C);
        checkOutput("b2b_ready_cycles", readyCnt, 1);

        // Stall: toggling data while not ready must not disturb the word in flight.
        streamM = '0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, (i == 0) ? 8'hC3 : (i[0] ? 8'h55 : 8'hAA));
            if (i < 8) streamM = {streamM[6:0], x};
        end
        checkOutput("stall_word", {24'd0, streamM}, 32'hC3);
        streamM = {7'd0, x};
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 8'($urandom));
            streamM = {streamM[6:0], x};
        end
        checkOutput("stall_next_word", {24'd0, streamM}, 32'hAA);
        applyStimulus(1'b0, 8'h00);

        // Reset during bit 4, then a fresh all-ones word.
        applyStimulus(1'b1, 8'h5A);
        repeat (3) applyStimulus(1'b0, 8'h00);
        resetMidWord();
        streamM = '0; lastCnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i == 0, 8'hFF);
            streamM  = {streamM[6:0], x & xValid};
            lastCnt += (lastBit && i == 7) ? 1 : 0;
        end
        checkOutput("ff_after_reset", {24'd0, streamM}, 32'hFF);
        checkOutput("ff_last_on_8th", lastCnt, 1);
        applyStimulus(1'b0, 8'h00);

        // A 011 detector on the serial stream fires on the cycles carrying bits 5 and 2.
        win = 3'b111;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i == 0, 8'h6C);
            win = {win[1:0], x};
            checkOutput($sformatf("detect_y_%0d", i), {31'd0, (win == 3'b011)}, {31'd0, (i == 2 || i == 5)});
        end
        applyStimulus(1'b0, 8'h00);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if (n % 97 == 50) resetMidWord();
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 Parameter IDLE_BIT, default 1: value driven on x when no word is being shifted.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port data_in, input, WIDTH: parallel word offered by the producer.
REQ-007 Port data_valid, input, 1: data_in holds a word for transfer.
REQ-008 Port data_ready, output, 1: block can accept a word this cycle.
REQ-009 Port x, output, 1: serial bit stream that directly drives the sequence detector's x input.
REQ-010 Port x_valid, output, 1: x carries a payload bit this cycle.
REQ-011 Port last_bit, output, 1: x carries the final bit of the current word.

Function
REQ-012 The block shall have exactly two states: IDLE and SHIFT.
REQ-013 Handshake: a word shall be accepted on a rising edge where data_valid=1 and data_ready=1; data_in is captured into an internal shift register at that edge.
REQ-014 data_ready shall be 1 in IDLE, and in SHIFT only while last_bit=1; data_ready shall be 0 otherwise.
REQ-015 data_ready shall not depend combinationally on data_valid.
REQ-016 Latency: the first bit of an accepted word shall appear on x in the cycle immediately after the accepting edge.
REQ-017 Each word shall be driven for exactly WIDTH consecutive cycles, one bit per cycle, in the order set by MSB_FIRST.
REQ-018 x_valid shall be 1 for all WIDTH bit cycles of a word.
REQ-019 A bit counter of width clog2(WIDTH) shall count from 0 to WIDTH-1 in SHIFT; last_bit shall be 1 when the count equals WIDTH-1.
REQ-020 IDLE to SHIFT transition: on acceptance.
REQ-021 SHIFT to IDLE transition: at the edge ending the last bit, when no word is accepted at that edge.
REQ-022 SHIFT to SHIFT transition (back-to-back): at the edge ending the last bit, when a word is accepted at that edge; the counter reloads to 0.
REQ-023 A back-to-back word shall start the next cycle with x_valid held at 1 and no idle gap.
REQ-024 In IDLE, x shall equal IDLE_BIT, x_valid=0 and last_bit=0.
REQ-025 Changes on data_in or data_valid while data_ready=0 shall have no effect on x, x_valid, the counter or the stored word.
REQ-026 x, x_valid and last_bit shall be driven from registers or from the state/counter only, glitch-free relative to clk, with no combinational path from any input.

Reset
REQ-027 While reset_n=0: state=IDLE, shift register=0, counter=0, x=IDLE_BIT, x_valid=0, last_bit=0, data_ready=1.
REQ-028 Reset asserted mid-word shall abort that word immediately, asynchronously; no partial bits shall be emitted after reset_n rises.
REQ-029 A handshake coincident with reset_n=0 shall be ignored.
REQ-030 The first acceptance shall be possible on the first rising edge after reset_n deasserts.

Verification
REQ-031 Single word: WIDTH=8, MSB_FIRST=1, accept 8'b0110_0110 -> x=0,1,1,0,0,1,1,0 on the next 8 cycles, x_valid=1 for all 8, last_bit=1 on cycle 8 only, then x=1 and x_valid=0.
REQ-032 LSB first: MSB_FIRST=0, accept 8'b0000_0110 -> x=0,1,1,0,0,0,0,0.
REQ-033 Back-to-back: data_valid held at 1 with words 8'hA5 then 8'h3C -> 16 contiguous valid bits; data_ready=1 only on the 8th bit cycle; second word accepted at that edge.
REQ-034 Stall: data_valid=1 during bits 1..7 of a word with data_in toggling each cycle -> no acceptance, output stream unchanged, acceptance occurs only on the last-bit edge.
REQ-035 Reset mid-word: reset_n=0 during bit 4 -> x=IDLE_BIT and x_valid=0 immediately; after release, a new word 8'hFF -> eight 1s with correct last_bit.
REQ-036 System check: serializer output feeding the 011 detector, word 8'b0110_1100 MSB first -> detector y=1 in the bit cycles carrying bits 5 and 2, where the detector's 011 completes.
